// File: rtl/letc_core_axi_fsm.sv
// LIMP responder: one LIMP request at a time becomes
// one single-beat AXI4 transaction on the core master port.
module letc_core_axi_fsm #(
  parameter int         PADDR_WIDTH = 32,
  parameter logic [3:0] AXI_ID      = 4'd0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_limp_valid,
  output logic                   o_limp_ready,
  input  logic                   i_limp_wen_nren,
  input  logic [1:0]             i_limp_size,
  input  logic [PADDR_WIDTH-1:0] i_limp_addr,
  output logic [31:0]            o_limp_rdata,
  input  logic [31:0]            i_limp_wdata,
  output logic                   o_limp_err,
  output logic                   o_axi_awvalid,
  input  logic                   i_axi_awready,
  output logic [PADDR_WIDTH-1:0] o_axi_awaddr,
  output logic [2:0]             o_axi_awsize,
  output logic [7:0]             o_axi_awlen,
  output logic [1:0]             o_axi_awburst,
  output logic [3:0]             o_axi_awid,
  output logic                   o_axi_wvalid,
  input  logic                   i_axi_wready,
  output logic [31:0]            o_axi_wdata,
  output logic [3:0]             o_axi_wstrb,
  output logic                   o_axi_wlast,
  input  logic                   i_axi_bvalid,
  output logic                   o_axi_bready,
  input  logic [1:0]             i_axi_bresp,
  output logic                   o_axi_arvalid,
  input  logic                   i_axi_arready,
  output logic [PADDR_WIDTH-1:0] o_axi_araddr,
  output logic [2:0]             o_axi_arsize,
  output logic [7:0]             o_axi_arlen,
  output logic [1:0]             o_axi_arburst,
  output logic [3:0]             o_axi_arid,
  input  logic                   i_axi_rvalid,
  output logic                   o_axi_rready,
  input  logic [31:0]            i_axi_rdata,
  input  logic [1:0]             i_axi_rresp
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_ADDR_DATA,
    WRITE_RESP,
    READ_ADDR,
    READ_DATA,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [PADDR_WIDTH-1:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        aw_pend_q;
  logic        w_pend_q;

  logic        misaligned;
  logic [1:0]  lane;
  logic [3:0]  strb;
  logic [31:0] rd_shift;
  logic [31:0] rd_mask;
  logic        wr_done;

  assign lane = i_limp_addr[1:0];

  always_comb begin
    misaligned = 1'b0;
    strb       = 4'b1111;
    unique case (i_limp_size)
      2'd0: strb = 4'b0001 << lane;
      2'd1: begin
        misaligned = lane[0];
        strb       = 4'b0011 << lane;
      end
      2'd2: misaligned = |lane;
      default: misaligned = 1'b1;
    endcase
  end

  assign rd_shift = i_axi_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    rd_mask = 32'hFFFF_FFFF;
    unique case (size_q)
      2'd0:    rd_mask = 32'h0000_00FF;
      2'd1:    rd_mask = 32'h0000_FFFF;
      default: rd_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Both channels finished: already done, or handshaking now.
  assign wr_done = (~aw_pend_q | i_axi_awready) &
                   (~w_pend_q  | i_axi_wready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_limp_valid) begin
        if (misaligned)           state_d = DONE;
        else if (i_limp_wen_nren) state_d = WRITE_ADDR_DATA;
        else                      state_d = READ_ADDR;
      end
      WRITE_ADDR_DATA: if (wr_done)       state_d = WRITE_RESP;
      WRITE_RESP:      if (i_axi_bvalid)  state_d = DONE;
      READ_ADDR:       if (i_axi_arready) state_d = READ_DATA;
      READ_DATA:       if (i_axi_rvalid)  state_d = DONE;
      DONE:            state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_limp_valid) begin
          addr_q    <= i_limp_addr;
          size_q    <= i_limp_size;
          wdata_q   <= i_limp_wdata << {lane, 3'b000};
          wstrb_q   <= strb;
          rdata_q   <= '0;
          err_q     <= misaligned;
          aw_pend_q <= ~misaligned & i_limp_wen_nren;
          w_pend_q  <= ~misaligned & i_limp_wen_nren;
        end
        WRITE_ADDR_DATA: begin
          if (i_axi_awready) aw_pend_q <= 1'b0;
          if (i_axi_wready)  w_pend_q  <= 1'b0;
        end
        WRITE_RESP: if (i_axi_bvalid)
          err_q <= |i_axi_bresp;
        READ_DATA: if (i_axi_rvalid) begin
          rdata_q <= rd_shift & rd_mask;
          err_q   <= |i_axi_rresp;
        end
        default: ;
      endcase
    end
  end

  assign o_limp_ready  = (state_q == DONE);
  assign o_limp_rdata  = rdata_q;
  assign o_limp_err    = err_q;

  assign o_axi_awvalid = aw_pend_q;
  assign o_axi_awaddr  = addr_q;
  assign o_axi_awsize  = {1'b0, size_q};
  assign o_axi_awlen   = 8'd0;
  assign o_axi_awburst = 2'b01;
  assign o_axi_awid    = AXI_ID;

  assign o_axi_wvalid  = w_pend_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = wstrb_q;
  assign o_axi_wlast   = 1'b1;

  assign o_axi_bready  = (state_q == WRITE_RESP);

  assign o_axi_arvalid = (state_q == READ_ADDR);
  assign o_axi_araddr  = addr_q;
  assign o_axi_arsize  = {1'b0, size_q};
  assign o_axi_arlen   = 8'd0;
  assign o_axi_arburst = 2'b01;
  assign o_axi_arid    = AXI_ID;

  assign o_axi_rready  = (state_q == READ_DATA);

endmodule

// File: tb/tb_letc_core_axi_fsm.sv
// Directed bench for letc_core_axi_fsm: AXI slave model
// plus a scoreboard of expected LIMP completions.
module tb_letc_core_axi_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        limp_valid, limp_ready, limp_wen;
  logic [1:0]  limp_size;
  logic [31:0] limp_addr, limp_rdata, limp_wdata;
  logic        limp_err;
  logic        awvalid, awready, wvalid, wready, wlast;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0]  awsize, arsize;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awid, arid, wstrb;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;
  logic [32:0] sb[$];

  int aw_dly, w_dly, ar_dly, r_dly, b_dly;
  logic [31:0] rdata_c;
  logic [1:0]  rresp_c, bresp_c;

  always #5 clk = ~clk;

  letc_core_axi_fsm #(.PADDR_WIDTH(32), .AXI_ID(4'd0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_limp_valid(limp_valid), .o_limp_ready(limp_ready),
    .i_limp_wen_nren(limp_wen), .i_limp_size(limp_size),
    .i_limp_addr(limp_addr), .o_limp_rdata(limp_rdata),
    .i_limp_wdata(limp_wdata), .o_limp_err(limp_err),
    .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_awaddr(awaddr), .o_axi_awsize(awsize),
    .o_axi_awlen(awlen), .o_axi_awburst(awburst),
    .o_axi_awid(awid),
    .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .o_axi_wdata(wdata), .o_axi_wstrb(wstrb),
    .o_axi_wlast(wlast),
    .i_axi_bvalid(bvalid), .o_axi_bready(bready),
    .i_axi_bresp(bresp),
    .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .o_axi_araddr(araddr), .o_axi_arsize(arsize),
    .o_axi_arlen(arlen), .o_axi_arburst(arburst),
    .o_axi_arid(arid),
    .i_axi_rvalid(rvalid), .o_axi_rready(rready),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int aw, input int w, input int ar,
                     input int r, input int b, input logic [31:0] rd,
                     input logic [1:0] rr, input logic [1:0] br);
    aw_dly = aw; w_dly = w; ar_dly = ar; r_dly = r; b_dly = b;
    rdata_c = rd; rresp_c = rr; bresp_c = br;
  endtask

  task automatic txn(input string tag, input logic we,
                     input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic axi,
                     input logic [31:0] exp_wd, input logic [3:0] exp_st,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat);
    int lat = -1;
    int viol = 0;
    int awn = 0, wn = 0, arn = 0, bn = 0, rn = 0;
    int awc = 0, wc = 0, arc = 0, rc = 0, bc = 0;
    bit aw_d = 0, w_d = 0, ar_d = 0, b_d = 0;
    bit aw_s = 0, w_s = 0, ar_s = 0;
    bit r_pend = 0, b_pend = 0, done = 0;
    logic [32:0] e, got;
    sb.push_back({exp_err, exp_rd});
    limp_valid = 1'b1; limp_wen = we; limp_size = sz;
    limp_addr = a; limp_wdata = wd;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clk); #1;
      if (limp_ready) begin
        lat = c;
        got = {limp_err, limp_rdata};
        e = sb.pop_front();
        chk({tag, ".rdata"}, 64'(got[31:0]), 64'(e[31:0]));
        chk({tag, ".err"}, 64'(got[32]), 64'(e[32]));
        done = 1;
        limp_valid = 1'b0;
      end
      if (!axi && (awvalid || wvalid || arvalid)) viol++;
      if (we && arvalid) viol++;
      if (!we && (awvalid || wvalid)) viol++;
      if (aw_d && awvalid) viol++;
      if (w_d && wvalid) viol++;
      if (ar_d && arvalid) viol++;
      if (aw_s && !aw_d && !awvalid) viol++;
      if (w_s && !w_d && !wvalid) viol++;
      if (ar_s && !ar_d && !arvalid) viol++;
      if (awvalid && !aw_s) begin
        aw_s = 1;
        chk({tag, ".awaddr"}, 64'(awaddr), 64'(a));
        chk({tag, ".awsize"}, 64'(awsize), 64'(sz));
      end
      if (wvalid && !w_s) begin
        w_s = 1;
        chk({tag, ".wdata"}, 64'(wdata), 64'(exp_wd));
        chk({tag, ".wstrb"}, 64'(wstrb), 64'(exp_st));
      end
      if (arvalid && !ar_s) begin
        ar_s = 1;
        chk({tag, ".araddr"}, 64'(araddr), 64'(a));
        chk({tag, ".arsize"}, 64'(arsize), 64'(sz));
      end
      awready = awvalid && awc >= aw_dly;
      if (awvalid && !awready) awc++;
      wready = wvalid && wc >= w_dly;
      if (wvalid && !wready) wc++;
      arready = arvalid && arc >= ar_dly;
      if (arvalid && !arready) arc++;
      bvalid = b_pend && bc >= b_dly;
      if (b_pend && !bvalid) bc++;
      bresp = bresp_c;
      rvalid = r_pend && rc >= r_dly;
      if (r_pend && !rvalid) rc++;
      rdata = rvalid ? rdata_c : 32'h0;
      rresp = rresp_c;
      if (awvalid && awready) begin aw_d = 1; awn++; end
      if (wvalid && wready) begin w_d = 1; wn++; end
      if (rvalid && rready) begin rn++; r_pend = 0; end
      if (arvalid && arready) begin ar_d = 1; arn++; r_pend = 1; end
      if (bvalid && bready) begin bn++; b_pend = 0; b_d = 1; end
      if (aw_d && w_d && !b_d) b_pend = 1;
    end
    if (!done) begin
      void'(sb.pop_front());
      limp_valid = 1'b0;
    end
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; rvalid = 0; rdata = 0;
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".aw_hs"}, 64'(awn), 64'(axi && we));
    chk({tag, ".w_hs"}, 64'(wn), 64'(axi && we));
    chk({tag, ".b_hs"}, 64'(bn), 64'(axi && we));
    chk({tag, ".ar_hs"}, 64'(arn), 64'(axi && !we));
    chk({tag, ".r_hs"}, 64'(rn), 64'(axi && !we));
    chk({tag, ".axi_rules"}, 64'(viol), 64'(0));
    @(posedge clk); #1;
    chk({tag, ".one_shot"}, 64'(limp_ready), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    limp_valid = 0; limp_wen = 0; limp_size = 0;
    limp_addr = 0; limp_wdata = 0;
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;
    cfg(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    #12;
    chk("rst.limp_ready", 64'(limp_ready), 64'(0));
    chk("rst.limp_err", 64'(limp_err), 64'(0));
    chk("rst.limp_rdata", 64'(limp_rdata), 64'(0));
    chk("rst.valids", 64'({awvalid, wvalid, arvalid}), 64'(0));
    chk("rst.readies", 64'({bready, rready}), 64'(0));
    chk("rst.awaddr", 64'(awaddr), 64'(0));
    chk("rst.wdata_strb", 64'({wdata, wstrb}), 64'(0));
    chk("const.len", 64'({awlen, arlen}), 64'(0));
    chk("const.burst", 64'({awburst, arburst}), 64'(4'b0101));
    chk("const.id_last", 64'({awid, arid, wlast}), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    cfg(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b00);
    txn("rd_word", 0, 2'd2, 32'h1000, 32'h0, 1,
        32'h0, 4'h0, 32'hDEAD_BEEF, 0, 3);

    cfg(2, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    txn("wr_byte", 1, 2'd0, 32'h1003, 32'h0000_00AB, 1,
        32'hAB00_0000, 4'b1000, 32'h0, 0, 5);

    cfg(0, 0, 0, 0, 0, 32'h1234_5678, 2'b00, 2'b00);
    txn("rd_half", 0, 2'd1, 32'h2002, 32'h0, 1,
        32'h0, 4'h0, 32'h0000_1234, 0, 3);

    txn("rd_misal", 0, 2'd2, 32'h3001, 32'h0, 0,
        32'h0, 4'h0, 32'h0, 1, 1);

    cfg(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b10);
    txn("wr_slverr", 1, 2'd2, 32'h5000, 32'hCAFE_F00D, 1,
        32'hCAFE_F00D, 4'b1111, 32'h0, 1, 3);

    cfg(0, 0, 0, 0, 0, 32'h1122_3344, 2'b00, 2'b00);
    txn("rd_after_err", 0, 2'd2, 32'h5000, 32'h0, 1,
        32'h0, 4'h0, 32'h1122_3344, 0, 3);

    cfg(0, 0, 0, 0, 0, 32'hA1B2_C3D4, 2'b00, 2'b00);
    txn("rd_byte1", 0, 2'd0, 32'h1001, 32'h0, 1,
        32'h0, 4'h0, 32'h0000_00C3, 0, 3);

    cfg(0, 3, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    txn("wr_half_wstall", 1, 2'd1, 32'h2002, 32'h0000_BEEF, 1,
        32'hBEEF_0000, 4'b1100, 32'h0, 0, 6);

    txn("wr_size3", 1, 2'd3, 32'h0000, 32'h1, 0,
        32'h0, 4'h0, 32'h0, 1, 1);

    cfg(0, 0, 1, 2, 0, 32'h0F0F_0F0F, 2'b10, 2'b00);
    txn("rd_stall_err", 0, 2'd2, 32'h6000, 32'h0, 1,
        32'h0, 4'h0, 32'h0F0F_0F0F, 1, 6);

    txn("rd_half_misal", 0, 2'd1, 32'h2001, 32'h0, 0,
        32'h0, 4'h0, 32'h0, 1, 1);

    // Reset while waiting in READ_DATA
    limp_valid = 1; limp_wen = 0; limp_size = 2'd2;
    limp_addr = 32'h4000;
    @(posedge clk); #1;
    chk("mid.arvalid", 64'(arvalid), 64'(1));
    arready = 1;
    @(posedge clk); #1;
    arready = 0;
    chk("mid.rready", 64'(rready), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid.rst_valids", 64'({arvalid, rready, limp_ready}), 64'(0));
    chk("mid.rst_addr", 64'(araddr), 64'(0));
    limp_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid.idle", 64'({arvalid, rready, limp_ready}), 64'(0));

    cfg(0, 0, 0, 0, 0, 32'h55AA_55AA, 2'b00, 2'b00);
    txn("rd_after_rst", 0, 2'd2, 32'h7000, 32'h0, 1,
        32'h0, 4'h0, 32'h55AA_55AA, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
